// File: rtl/counter_alu_scan.sv
// Two loadable up/down counters feeding a registered 4-function ALU, shown on an
// 8-digit multiplexed 7-segment display. Define COUNTER_SATURATE_EN to saturate the counters instead of wrapping.
module counter_alu_scan #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic             clkt,
    input  logic             rst,
    input  logic [WIDTH-1:0] asw,
    input  logic [WIDTH-1:0] bsw,
    input  logic             aud,
    input  logic             bud,
    input  logic             aload,
    input  logic             bload,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] cnt_a,
    output logic [WIDTH-1:0] cnt_b,
    output logic [WIDTH:0]   res,
    output logic [6:0]       Cnode,
    output logic             dp,
    output logic [7:0]       AN
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [SW-1:0] scan_cnt;
    logic          scan_adv;
    logic [2:0]    scan_idx;
    logic [2:0]    idx_nxt;
    logic [7:0]    a_ext;
    logic [7:0]    b_ext;
    logic [11:0]   r_ext;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [WIDTH-1:0] step_cnt(input logic [WIDTH-1:0] v, input logic up);
`ifdef COUNTER_SATURATE_EN
        if (up)
            return (v == '1) ? v : v + WIDTH'(1);
        return (v == '0) ? v : v - WIDTH'(1);
`else
        return up ? v + WIDTH'(1) : v - WIDTH'(1);
`endif
    endfunction

    // Subtraction is done in WIDTH+1 signed bits so the top bit reads as borrow.
    function automatic logic [WIDTH:0] alu(input logic [1:0] sel,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        logic signed [WIDTH:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        case (sel)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return $unsigned(diff);
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
    assign scan_adv = (scan_cnt == SW'(SCAN_DIV - 1));
    assign idx_nxt  = scan_adv ? scan_idx + 3'd1 : scan_idx;
    assign a_ext    = 8'(cnt_a);
    assign b_ext    = 8'(cnt_b);
    assign r_ext    = 12'(res);
    assign dp       = 1'b1;

    // Digit content is chosen for the index about to be shown, so AN and Cnode change together.
    always_comb begin
        nib   = 4'h0;
        blank = 1'b0;
        case (idx_nxt)
            3'd7:    nib = a_ext[7:4];
            3'd6:    nib = a_ext[3:0];
            3'd5:    nib = b_ext[7:4];
            3'd4:    nib = b_ext[3:0];
            3'd3:    blank = 1'b1;
            3'd2:    nib = r_ext[11:8];
            3'd1:    nib = r_ext[7:4];
            default: nib = r_ext[3:0];
        endcase
    end

    always_ff @(posedge clkt or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            scan_cnt <= '0;
            scan_idx <= 3'd0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            scan_cnt <= scan_adv ? '0 : scan_cnt + SW'(1);
            scan_idx <= idx_nxt;
        end
    end

    // Stage 0 -> 1: counters; stage 1 -> 2: ALU result and display registers.
    always_ff @(posedge clkt or posedge rst) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (aload)
                cnt_a <= asw;
            else if (tick)
                cnt_a <= step_cnt(cnt_a, aud);
            if (bload)
                cnt_b <= bsw;
            else if (tick)
                cnt_b <= step_cnt(cnt_b, bud);
        end
    end

    always_ff @(posedge clkt or posedge rst) begin
        if (rst) begin
            res   <= '0;
            AN    <= 8'hFE;
            Cnode <= 7'b1000000;
        end else begin
            res   <= alu(op, cnt_a, cnt_b);
            AN    <= ~(8'd1 << idx_nxt);
            Cnode <= blank ? 7'b1111111 : hex7(nib);
        end
    end

endmodule

// File: tb/tb_counter_alu_scan.sv
// Randomized bench for counter_alu_scan with a cycle-count based reference model
// plus directed scenarios for load priority, wrap/saturate, borrow and digit scan.
module tb_counter_alu_scan;

    localparam int WIDTH    = 4;
    localparam int TICK_DIV = 2;
    localparam int SCAN_DIV = 2;
    localparam int MAXV     = (1 << WIDTH) - 1;
    localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic             clkt = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] asw, bsw;
    logic             aud, bud, aload, bload;
    logic [1:0]       op;
    logic [WIDTH-1:0] cnt_a, cnt_b;
    logic [WIDTH:0]   res;
    logic [6:0]       Cnode;
    logic             dp;
    logic [7:0]       AN;

    int checks   = 0;
    int failures = 0;
    int n, ma, mb, mr, man, mseg;

    always #5 clkt = ~clkt;

    counter_alu_scan #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clkt(clkt), .rst(rst), .asw(asw), .bsw(bsw), .aud(aud), .bud(bud),
        .aload(aload), .bload(bload), .op(op), .cnt_a(cnt_a), .cnt_b(cnt_b),
        .res(res), .Cnode(Cnode), .dp(dp), .AN(AN)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int step(input int v, input bit up);
`ifdef COUNTER_SATURATE_EN
        if (up) return (v == MAXV) ? v : v + 1;
        return (v == 0) ? 0 : v - 1;
`else
        return up ? (v + 1) % (MAXV + 1) : (v + MAXV) % (MAXV + 1);
`endif
    endfunction

    function automatic int alu(input int o, input int a, input int b);
        if (o == 0) return a + b;
        if (o == 1) return (a - b) & ((1 << (WIDTH + 1)) - 1);
        if (o == 2) return a & b;
        return a | b;
    endfunction

    // Returns the nibble shown on a digit, or -1 for the blank digit.
    function automatic int digit(input int idx, input int a, input int b, input int r);
        case (idx)
            7: return (a >> 4) & 15;
            6: return a & 15;
            5: return (b >> 4) & 15;
            4: return b & 15;
            3: return -1;
            2: return (r >> 8) & 15;
            1: return (r >> 4) & 15;
            default: return r & 15;
        endcase
    endfunction

    task automatic model_reset();
        n = 0; ma = 0; mb = 0; mr = 0; man = 'hFE; mseg = 'h40;
    endtask

    task automatic check_rst(input string tag);
        check({tag, ".cnt_a"}, 32'(cnt_a), 0);
        check({tag, ".cnt_b"}, 32'(cnt_b), 0);
        check({tag, ".res"},   32'(res),   0);
        check({tag, ".AN"},    32'(AN),    32'hFE);
        check({tag, ".Cnode"}, 32'(Cnode), 32'h40);
        check({tag, ".dp"},    32'(dp),    1);
    endtask

    task automatic cycle(input int a_in, input int b_in, input bit au, input bit bu,
                         input bit al, input bit bl, input int o);
        int na, nb, nr, idx, d;
        bit tick;
        asw = WIDTH'(a_in); bsw = WIDTH'(b_in); aud = au; bud = bu;
        aload = al; bload = bl; op = 2'(o);
        tick = (n % TICK_DIV) == TICK_DIV - 1;
        na   = al ? (a_in & MAXV) : (tick ? step(ma, au) : ma);
        nb   = bl ? (b_in & MAXV) : (tick ? step(mb, bu) : mb);
        nr   = alu(o & 3, ma, mb);
        idx  = ((n + 1) / SCAN_DIV) % 8;
        man  = ~(1 << idx) & 'hFF;
        d    = digit(idx, ma, mb, mr);
        mseg = (d < 0) ? 'h7F : int'(SEG_TBL[d]);
        @(posedge clkt); #1;
        n++; ma = na; mb = nb; mr = nr;
        check("cnt_a", 32'(cnt_a), ma);
        check("cnt_b", 32'(cnt_b), mb);
        check("res",   32'(res),   mr);
        check("AN",    32'(AN),    man);
        check("Cnode", 32'(Cnode), mseg);
        check("dp",    32'(dp),    1);
    endtask

    task automatic random_cycle();
        cycle($urandom_range(MAXV), $urandom_range(MAXV), 1'($urandom), 1'($urandom),
              $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3));
    endtask

    initial begin
        logic [6:0] exp39 [8];
        exp39 = '{7'h10, 7'h40, 7'h40, 7'h7F, 7'h10, 7'h40, 7'h00, 7'h40};
        rst = 1'b0; asw = '0; bsw = '0; aud = 0; bud = 0; aload = 0; bload = 0; op = 0;
        #1 rst = 1'b1;
        #2 check_rst("por");
        repeat (3) @(posedge clkt);
        #1 check_rst("por_hold");
        rst = 1'b0;
        model_reset();

        // Load then add: counters next edge, sum one edge later.
        cycle(4, 2, 0, 0, 1, 1, 0);
        check("ld35.cnt_a", 32'(cnt_a), 4);
        check("ld35.cnt_b", 32'(cnt_b), 2);
        cycle(4, 2, 0, 0, 1, 1, 0);
        check("add35.res", 32'(res), 6);

        // Subtract with borrow.
        cycle(3, 6, 0, 0, 1, 1, 1);
        cycle(3, 6, 0, 0, 1, 1, 1);
        check("sub36.res", 32'(res), 32'b11101);

        // Overflow at top of range.
        cycle(MAXV, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < TICK_DIV; i++) cycle(0, 0, 1, 0, 0, 0, 0);
`ifdef COUNTER_SATURATE_EN
        check("ovf37.cnt_a", 32'(cnt_a), MAXV);
`else
        check("ovf37.cnt_a", 32'(cnt_a), 0);
`endif

        // Load wins over a step on a tick cycle.
        for (int i = 0; i < TICK_DIV && (n % TICK_DIV) != TICK_DIV - 1; i++) cycle(0, 0, 1, 0, 0, 0, 0);
        check("prio38.tick_phase", n % TICK_DIV, TICK_DIV - 1);
        cycle(8, 0, 1, 0, 1, 0, 0);
        check("prio38.cnt_a", 32'(cnt_a), 8);

        // Display scan with A=8, B=9, OR.
        cycle(8, 9, 0, 0, 1, 1, 3);
        cycle(8, 9, 0, 0, 1, 1, 3);
        for (int i = 0; i < 16; i++) begin
            cycle(8, 9, 0, 0, 1, 1, 3);
            for (int k = 0; k < 8; k++)
                if (AN == ~(8'd1 << k)) check($sformatf("scan39.dig%0d", k), 32'(Cnode), 32'(exp39[k]));
        end

        for (int i = 0; i < 200; i++) random_cycle();

        // Asynchronous reset mid-run; loads while in reset are ignored.
        rst = 1'b1;
        #1 check_rst("rst34");
        for (int i = 0; i < 3; i++) begin
            asw = WIDTH'($urandom); bsw = WIDTH'($urandom); aload = 1; bload = 1; op = 2'($urandom);
            @(posedge clkt); #1;
            check_rst("rst30");
        end
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < TICK_DIV + 2; i++) cycle(0, 0, 1, 1, 0, 0, 0);
        check("rst29.cnt_a", 32'(cnt_a), step(step(0, 1), 1));

        for (int i = 0; i < 300; i++) random_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
